// File: rtl/hazard_pkg.sv
// Shared opcode constants, tag record and opcode-class decode for the hazard scoreboard.
package hazard_pkg;

  localparam int OP_W   = 4;
  localparam int FWD_W  = 3;
  localparam int TAG_DW = 8;

  localparam logic [OP_W-1:0] OP_ALU_LO = 4'd1;
  localparam logic [OP_W-1:0] OP_ALU_HI = 4'd8;
  localparam logic [OP_W-1:0] OP_IMM    = 4'd9;
  localparam logic [OP_W-1:0] OP_LD     = 4'd10;
  localparam logic [OP_W-1:0] OP_ST     = 4'd11;
  localparam logic [OP_W-1:0] OP_BR     = 4'd12;

  // dest is stored at TAG_DW bits so one record type serves any REG_AW <= TAG_DW
  typedef struct packed {
    logic              valid;
    logic [TAG_DW-1:0] dest;
    logic              is_load;
  } tag_t;

  function automatic logic reads_r1(input logic [OP_W-1:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_BR);
  endfunction

  function automatic logic reads_r2(input logic [OP_W-1:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  function automatic logic reads_wd(input logic [OP_W-1:0] op);
    return op == OP_ST;
  endfunction

  function automatic logic writes_wd(input logic [OP_W-1:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_LD);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle: instruction fields in, stall/forward selects and stall counter out.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) ();
  import hazard_pkg::*;

  logic              dec_valid;
  logic [OP_W-1:0]   opcode;
  logic [REG_AW-1:0] r1;
  logic [REG_AW-1:0] r2;
  logic [REG_AW-1:0] wd;
  logic              flush;
  logic              stall;
  logic [FWD_W-1:0]  fwd1;
  logic [FWD_W-1:0]  fwd2;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output dec_valid, opcode, r1, r2, wd, flush,
    input  stall, fwd1, fwd2, stall_cnt
  );

  modport slave (
    input  dec_valid, opcode, r1, r2, wd, flush,
    output stall, fwd1, fwd2, stall_cnt
  );

endinterface

// File: rtl/hazard_tag_pipe.sv
// Shift register of in-flight destination tags; entry 0 is stage 1 (exec).
module hazard_tag_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_vld,
  input  logic [REG_AW-1:0]     i_dest,
  input  logic                  i_is_load,
  output tag_t [DEPTH-1:0]      o_tags
);

  logic [DEPTH-1:0]  r_vld;
  logic [REG_AW-1:0] r_dest [DEPTH];
  logic [DEPTH-1:0]  r_ld;

  // Only the valid bits need reset/flush; payload is ignored while invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_dest[0] <= i_dest;
    r_ld[0]   <= i_is_load;
    for (int k = 1; k < DEPTH; k++) begin
      r_dest[k] <= r_dest[k-1];
      r_ld[k]   <= r_ld[k-1];
    end
  end

  always_comb begin
    o_tags = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_tags[k].valid   = r_vld[k];
      o_tags[k].dest    = TAG_DW'(r_dest[k]);
      o_tags[k].is_load = r_ld[k];
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard unit: compares sources against its own tag pipeline and
// produces stall (and forwarding selects when FWD_EN=1) plus a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_scoreboard_if.slave bus
);

  tag_t [DEPTH-1:0]  w_tags;
  logic              w_rd1;
  logic              w_rd2;
  logic [REG_AW-1:0] w_src2;
  logic [FWD_W-1:0]  w_k1;
  logic [FWD_W-1:0]  w_k2;
  logic              w_raw;
  logic              w_ld_use;
  logic              w_stall;
  logic              w_issue;
  logic [CNT_W-1:0]  r_stall_cnt;

  always_comb begin
    w_rd1  = reads_r1(bus.opcode) && (bus.r1 != '0);
    // a store's data register travels on the second source path
    w_src2 = reads_wd(bus.opcode) ? bus.wd : bus.r2;
    w_rd2  = (reads_r2(bus.opcode) || reads_wd(bus.opcode)) && (w_src2 != '0);
    w_k1   = '0;
    w_k2   = '0;
    // scan oldest to youngest so the youngest matching producer is left in w_kX
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_rd1 && w_tags[k].valid && (w_tags[k].dest == TAG_DW'(bus.r1))) begin
        w_k1 = FWD_W'(k + 1);
      end
      if (w_rd2 && w_tags[k].valid && (w_tags[k].dest == TAG_DW'(w_src2))) begin
        w_k2 = FWD_W'(k + 1);
      end
    end
    w_raw    = (w_k1 != '0) || (w_k2 != '0);
    w_ld_use = w_tags[0].is_load && ((w_k1 == FWD_W'(1)) || (w_k2 == FWD_W'(1)));
    w_stall  = bus.dec_valid && !bus.flush && ((FWD_EN != 0) ? w_ld_use : w_raw);
    w_issue  = bus.dec_valid && writes_wd(bus.opcode) && (bus.wd != '0)
               && !w_stall && !bus.flush;
  end

  hazard_tag_pipe #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (bus.flush),
    .i_vld     (w_issue),
    .i_dest    (bus.wd),
    .i_is_load (bus.opcode == OP_LD),
    .o_tags    (w_tags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall     = w_stall;
  assign bus.fwd1      = (FWD_EN != 0) ? w_k1 : '0;
  assign bus.fwd2      = (FWD_EN != 0) ? w_k2 : '0;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one stall-only and one forwarding instance driven in lockstep,
// expectations from a producer-history model queued per cycle and popped on the falling edge.
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;

  typedef struct {bit dv; int op; int a; int b; int w; bit fl;} stim_t;
  typedef struct {bit st; int f1; int f2; int cnt;} exp_t;
  typedef struct {int c; int dest; bit ld;} rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(3), .CNT_W(16)) if0 ();
  hazard_scoreboard_if #(.REG_AW(3), .CNT_W(16)) if1 ();

  hazard_scoreboard #(.REG_AW(3), .DEPTH(DEPTH), .FWD_EN(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  hazard_scoreboard #(.REG_AW(3), .DEPTH(DEPTH), .FWD_EN(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  rec_t recs0[$];
  rec_t recs1[$];

  function automatic stim_t mk(bit dv, int op, int a, int b, int w, bit fl);
    stim_t s;
    s.dv = dv; s.op = op; s.a = a; s.b = b; s.w = w; s.fl = fl;
    return s;
  endfunction

  // producer issued at cycle t sits in stage (now - t) while that is 1..DEPTH
  function automatic int find_k(input rec_t q[$], input int src, input int now, output bit ld);
    int best = 0;
    ld = 1'b0;
    foreach (q[i]) begin
      int k;
      k = now - q[i].c;
      if (k >= 1 && k <= DEPTH && q[i].dest == src && (best == 0 || k < best)) begin
        best = k;
        ld = q[i].ld;
      end
    end
    return best;
  endfunction

  task automatic model_step(input stim_t s);
    bit rd1, rd2, wr, l1, l2, st;
    int src2, k1, k2;
    rec_t q[$];
    exp_t e;
    rd1  = (s.op >= 1) && (s.op <= 12);
    rd2  = ((s.op >= 1) && (s.op <= 8)) || (s.op == 11);
    src2 = (s.op == 11) ? s.w : s.b;
    wr   = (s.op >= 1) && (s.op <= 10);
    for (int m = 0; m < 2; m++) begin
      if (m == 0) q = recs0; else q = recs1;
      k1 = 0; k2 = 0; l1 = 1'b0; l2 = 1'b0;
      if (rd1 && s.a != 0) k1 = find_k(q, s.a, cyc, l1);
      if (rd2 && src2 != 0) k2 = find_k(q, src2, cyc, l2);
      if (m == 0) st = s.dv && (k1 != 0 || k2 != 0);
      else        st = s.dv && ((k1 == 1 && l1) || (k2 == 1 && l2));
      if (s.fl) st = 1'b0;
      e.st  = st;
      e.f1  = (m == 1) ? k1 : 0;
      e.f2  = (m == 1) ? k2 : 0;
      e.cnt = (m == 0) ? cnt0 : cnt1;
      if (m == 0) begin q0.push_back(e); if (st) cnt0++; end
      else        begin q1.push_back(e); if (st) cnt1++; end
      if (s.fl) q.delete();
      else if (s.dv && wr && s.w != 0 && !st) q.push_back('{cyc, s.w, (s.op == 10)});
      if (m == 0) recs0 = q; else recs1 = q;
    end
  endtask

  task automatic set_inputs(input stim_t s);
    if0.dec_valid = s.dv; if0.opcode = 4'(s.op); if0.r1 = 3'(s.a);
    if0.r2 = 3'(s.b); if0.wd = 3'(s.w); if0.flush = s.fl;
    if1.dec_valid = s.dv; if1.opcode = 4'(s.op); if1.r1 = 3'(s.a);
    if1.r2 = 3'(s.b); if1.wd = 3'(s.w); if1.flush = s.fl;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    set_inputs(s);
    model_step(s);
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t e0, e1;
    set_inputs(mk(1, 2, 3, 0, 0, 0));
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if (if0.stall !== 1'b0 || if0.fwd1 !== 3'd0 || if0.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_dut0 stall/fwd1/cnt got %b/%0d/%0d want 0/0/0", if0.stall, if0.fwd1, if0.stall_cnt);
    end
    checks++;
    if (if1.stall !== 1'b0 || if1.fwd1 !== 3'd0 || if1.fwd2 !== 3'd0 || if1.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_dut1 stall/fwd1/fwd2/cnt got %b/%0d/%0d/%0d want 0/0/0/0",
               if1.stall, if1.fwd1, if1.fwd2, if1.stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s.push_back(mk(1, 2, 3, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (if0.stall !== e0.st || if0.fwd1 !== 3'(e0.f1) || if0.fwd2 !== 3'(e0.f2) || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL reset_seq dut0 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if0.stall, if0.fwd1, if0.fwd2, if0.stall_cnt, e0.st, e0.f1, e0.f2, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.fwd2 !== 3'(e1.f2) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL reset_seq dut1 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.fwd2, if1.stall_cnt, e1.st, e1.f1, e1.f2, e1.cnt);
      end
    end
  endtask

  task automatic test_stall_nofwd();
    stim_t s[$];
    exp_t e0, e1;
    int nst = 0;
    int c0;
    c0 = int'(if0.stall_cnt);
    s.push_back(mk(1, 1, 0, 0, 3, 0));
    repeat (4) s.push_back(mk(1, 2, 3, 0, 7, 0));
    repeat (4) s.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      if (i >= 1 && i <= 4) nst += int'(if0.stall);
      checks++;
      if (if0.stall !== e0.st || if0.fwd1 !== 3'(e0.f1) || if0.fwd2 !== 3'(e0.f2) || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL raw_stall dut0 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if0.stall, if0.fwd1, if0.fwd2, if0.stall_cnt, e0.st, e0.f1, e0.f2, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.fwd2 !== 3'(e1.f2) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL raw_stall dut1 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.fwd2, if1.stall_cnt, e1.st, e1.f1, e1.f2, e1.cnt);
      end
      if (i == 1) begin
        checks++;
        if (if1.stall !== 1'b0 || if1.fwd1 !== 3'd1) begin
          errors++;
          $display("FAIL alu_fwd1 dut1 stall/fwd1 got %b/%0d want 0/1", if1.stall, if1.fwd1);
        end
      end
    end
    checks++;
    if (nst != DEPTH) begin
      errors++;
      $display("FAIL raw_stall_cycles dut0 got %0d want %0d", nst, DEPTH);
    end
    checks++;
    if (int'(if0.stall_cnt) != c0 + 3) begin
      errors++;
      $display("FAIL raw_stall_cnt dut0 got %0d want %0d", if0.stall_cnt, c0 + 3);
    end
  endtask

  task automatic test_zero_reg();
    stim_t s[$];
    exp_t e0, e1;
    s.push_back(mk(1, 1, 0, 0, 0, 0));
    repeat (2) s.push_back(mk(1, 2, 0, 0, 0, 0));
    repeat (3) s.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (if0.stall !== e0.st || if0.fwd1 !== 3'(e0.f1) || if0.fwd2 !== 3'(e0.f2) || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL zero_reg dut0 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if0.stall, if0.fwd1, if0.fwd2, if0.stall_cnt, e0.st, e0.f1, e0.f2, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.fwd2 !== 3'(e1.f2) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL zero_reg dut1 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.fwd2, if1.stall_cnt, e1.st, e1.f1, e1.f2, e1.cnt);
      end
      if (i == 1) begin
        checks++;
        if (if0.stall !== 1'b0 || if1.stall !== 1'b0 || if1.fwd1 !== 3'd0) begin
          errors++;
          $display("FAIL zero_reg_direct stall0/stall1/fwd1 got %b/%b/%0d want 0/0/0", if0.stall, if1.stall, if1.fwd1);
        end
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    exp_t e0, e1;
    s.push_back(mk(1, 10, 1, 0, 5, 0));
    repeat (2) s.push_back(mk(1, 1, 0, 5, 0, 0));
    repeat (4) s.push_back(mk(0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 5, 0));
    s.push_back(mk(1, 1, 0, 5, 0, 0));
    repeat (4) s.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (if0.stall !== e0.st || if0.fwd1 !== 3'(e0.f1) || if0.fwd2 !== 3'(e0.f2) || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL load_use dut0 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if0.stall, if0.fwd1, if0.fwd2, if0.stall_cnt, e0.st, e0.f1, e0.f2, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.fwd2 !== 3'(e1.f2) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL load_use dut1 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.fwd2, if1.stall_cnt, e1.st, e1.f1, e1.f2, e1.cnt);
      end
      if (i == 1) begin
        checks++;
        if (if1.stall !== 1'b1) begin
          errors++;
          $display("FAIL load_use_bubble dut1 stall got %b want 1", if1.stall);
        end
      end
      if (i == 2) begin
        checks++;
        if (if1.stall !== 1'b0 || if1.fwd2 !== 3'd2) begin
          errors++;
          $display("FAIL load_use_fwd dut1 stall/fwd2 got %b/%0d want 0/2", if1.stall, if1.fwd2);
        end
      end
      if (i == 8) begin
        checks++;
        if (if1.stall !== 1'b0 || if1.fwd2 !== 3'd1) begin
          errors++;
          $display("FAIL alu_fwd2 dut1 stall/fwd2 got %b/%0d want 0/1", if1.stall, if1.fwd2);
        end
      end
    end
  endtask

  task automatic test_youngest();
    stim_t s[$];
    exp_t e0, e1;
    s.push_back(mk(1, 1, 0, 0, 4, 0));
    s.push_back(mk(1, 9, 0, 0, 2, 0));
    s.push_back(mk(1, 1, 0, 0, 4, 0));
    s.push_back(mk(1, 3, 4, 0, 0, 0));
    repeat (4) s.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (if0.stall !== e0.st || if0.fwd1 !== 3'(e0.f1) || if0.fwd2 !== 3'(e0.f2) || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL youngest dut0 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if0.stall, if0.fwd1, if0.fwd2, if0.stall_cnt, e0.st, e0.f1, e0.f2, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.fwd2 !== 3'(e1.f2) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL youngest dut1 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.fwd2, if1.stall_cnt, e1.st, e1.f1, e1.f2, e1.cnt);
      end
      if (i == 3) begin
        checks++;
        if (if1.stall !== 1'b0 || if1.fwd1 !== 3'd1) begin
          errors++;
          $display("FAIL youngest_direct dut1 stall/fwd1 got %b/%0d want 0/1", if1.stall, if1.fwd1);
        end
      end
    end
  endtask

  task automatic test_store();
    stim_t s[$];
    exp_t e0, e1;
    s.push_back(mk(1, 1, 0, 0, 6, 0));
    s.push_back(mk(1, 11, 0, 5, 6, 0));
    repeat (4) s.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (if0.stall !== e0.st || if0.fwd1 !== 3'(e0.f1) || if0.fwd2 !== 3'(e0.f2) || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL store dut0 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if0.stall, if0.fwd1, if0.fwd2, if0.stall_cnt, e0.st, e0.f1, e0.f2, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.fwd2 !== 3'(e1.f2) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL store dut1 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.fwd2, if1.stall_cnt, e1.st, e1.f1, e1.f2, e1.cnt);
      end
      if (i == 1) begin
        checks++;
        if (if0.stall !== 1'b1 || if1.stall !== 1'b0 || if1.fwd2 !== 3'd1) begin
          errors++;
          $display("FAIL store_direct stall0/stall1/fwd2 got %b/%b/%0d want 1/0/1", if0.stall, if1.stall, if1.fwd2);
        end
      end
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    exp_t e0, e1;
    s.push_back(mk(1, 1, 0, 0, 3, 0));
    s.push_back(mk(1, 2, 3, 0, 0, 0));
    s.push_back(mk(1, 2, 3, 0, 0, 1));
    s.push_back(mk(1, 2, 3, 0, 0, 0));
    repeat (4) s.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (if0.stall !== e0.st || if0.fwd1 !== 3'(e0.f1) || if0.fwd2 !== 3'(e0.f2) || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL flush dut0 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if0.stall, if0.fwd1, if0.fwd2, if0.stall_cnt, e0.st, e0.f1, e0.f2, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.fwd2 !== 3'(e1.f2) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL flush dut1 cyc %0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.fwd2, if1.stall_cnt, e1.st, e1.f1, e1.f2, e1.cnt);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (if0.stall !== 1'b0) begin
          errors++;
          $display("FAIL flush_direct dut0 step %0d stall got %b want 0", i, if0.stall);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s[$];
    stim_t t[$];
    exp_t e0, e1;
    s.push_back(mk(1, 1, 0, 0, 3, 0));
    s.push_back(mk(1, 2, 3, 0, 0, 0));
    t.push_back(mk(1, 2, 3, 0, 0, 0));
    repeat (2) t.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (if0.stall !== e0.st || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL pre_reset dut0 cyc %0d stall/cnt got %b/%0d want %b/%0d", cyc, if0.stall, if0.stall_cnt, e0.st, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL pre_reset dut1 cyc %0d stall/fwd1/cnt got %b/%0d/%0d want %b/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.stall_cnt, e1.st, e1.f1, e1.cnt);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    recs0.delete(); recs1.delete(); cnt0 = 0; cnt1 = 0;
    checks++;
    if (if0.stall !== 1'b0 || if0.stall_cnt !== 16'd0 || if1.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset stall0/cnt0/cnt1 got %b/%0d/%0d want 0/0/0", if0.stall, if0.stall_cnt, if1.stall_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e0 = q0.pop_front(); e1 = q1.pop_front();
      checks++;
      if (if0.stall !== e0.st || if0.fwd1 !== 3'(e0.f1) || if0.stall_cnt !== 16'(e0.cnt)) begin
        errors++;
        $display("FAIL post_reset dut0 cyc %0d stall/fwd1/cnt got %b/%0d/%0d want %b/%0d/%0d", cyc,
                 if0.stall, if0.fwd1, if0.stall_cnt, e0.st, e0.f1, e0.cnt);
      end
      checks++;
      if (if1.stall !== e1.st || if1.fwd1 !== 3'(e1.f1) || if1.stall_cnt !== 16'(e1.cnt)) begin
        errors++;
        $display("FAIL post_reset dut1 cyc %0d stall/fwd1/cnt got %b/%0d/%0d want %b/%0d/%0d", cyc,
                 if1.stall, if1.fwd1, if1.stall_cnt, e1.st, e1.f1, e1.cnt);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stall_nofwd();
    test_zero_reg();
    test_load_use();
    test_youngest();
    test_store();
    test_flush();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
